// File: rtl/key_digit_collector.sv
// Debounced key collector behind a 74HC147-style active-low encoder; shifts digits into a BCD entry buffer.
// Optional auto-repeat while a key is held: define KEY_AUTOREPEAT_EN.
module key_digit_collector #(
    parameter int DEB_CYCLES    = 4,
    parameter int DIGITS        = 4,
    parameter int REPEAT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            Y_n,
    input  logic                  clr,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [3:0]            digit_cnt,
    output logic                  key_evt,
    output logic [3:0]            key_code,
    output logic                  err,
    output logic                  ovf
);

    typedef enum logic [1:0] {IDLE, DEB, HELD} state_t;

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [3:0] DIG_N    = 4'(DIGITS);

    generate
        if (DEB_CYCLES < 2 || DEB_CYCLES > 255 || DIGITS < 1 || DIGITS > 8 || REPEAT_CYCLES < 1) begin : g_param_check
            $error("key_digit_collector: illegal parameter value");
        end
    endgenerate

    state_t              state;
    logic [3:0]          sync1, sync2, k, cand;
    logic [7:0]          cnt;
    logic                deb_done, rep_fire, accept, digit_ok;
    logic [4*DIGITS-1:0] bcd_shift;

    assign k        = ~sync2;
    assign deb_done = (state == DEB) && (k == cand) && (cnt == DEB_LAST);
    assign accept   = deb_done || rep_fire;
    assign digit_ok = (cand >= 4'd1) && (cand <= 4'd9);

    generate
        if (DIGITS == 1) begin : g_shift1
            assign bcd_shift = cand;
        end else begin : g_shiftn
            assign bcd_shift = {out_bcd[4*DIGITS-5:0], cand};
        end
    endgenerate

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [15:0] REP_LAST = 16'(REPEAT_CYCLES - 1);
    logic [15:0] rep_cnt;

    assign rep_fire = (state == HELD) && (k == cand) && (rep_cnt == REP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= '0;
        end else if (deb_done || rep_fire || state != HELD || k != cand) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + 16'd1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
        end else begin
            sync1 <= Y_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            digit_cnt <= '0;
            key_evt   <= 1'b0;
            key_code  <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            key_evt <= 1'b0;
            err     <= 1'b0;
            ovf     <= 1'b0;

            case (state)
                IDLE: begin
                    if (k != 4'd0) begin
                        state <= DEB;
                        cand  <= k;
                        cnt   <= 8'd1;
                    end
                end
                DEB: begin
                    if (k == 4'd0) begin
                        state <= IDLE;
                    end else if (k != cand) begin
                        cand <= k;
                        cnt  <= 8'd1;
                    end else if (cnt == DEB_LAST) begin
                        state <= HELD;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HELD: begin
                    // any nonzero code while held restarts the release window
                    if (k != 4'd0) begin
                        cnt <= 8'd0;
                    end else if (cnt == DEB_LAST) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (clr) begin
                out_valid <= 1'b0;
                out_bcd   <= '0;
                digit_cnt <= '0;
            end else begin
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                    out_bcd   <= '0;
                    digit_cnt <= '0;
                end
                // a digit arriving in the handshake cycle still sees out_valid=1 and is dropped
                if (accept) begin
                    if (!digit_ok) begin
                        err <= 1'b1;
                    end else if (out_valid) begin
                        ovf <= 1'b1;
                    end else begin
                        out_bcd   <= bcd_shift;
                        digit_cnt <= digit_cnt + 4'd1;
                        key_evt   <= 1'b1;
                        key_code  <= cand;
                        if (digit_cnt + 4'd1 == DIG_N) out_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_key_digit_collector.sv
// Directed bench for key_digit_collector at default parameters; expects auto-repeat only when KEY_AUTOREPEAT_EN is defined.
module tb_key_digit_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  Y_n;
    logic        clr;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_bcd;
    logic [3:0]  digit_cnt;
    logic        key_evt;
    logic [3:0]  key_code;
    logic        err;
    logic        ovf;

    int vecs = 0;
    int errs = 0;
    int ev_n = 0;
    int err_n = 0;
    int ovf_n = 0;
    int first_evt;
    int ev_base;

    key_digit_collector dut (
        .clk(clk), .rst_n(rst_n), .Y_n(Y_n), .clr(clr), .out_ready(out_ready),
        .out_valid(out_valid), .out_bcd(out_bcd), .digit_cnt(digit_cnt),
        .key_evt(key_evt), .key_code(key_code), .err(err), .ovf(ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (key_evt) ev_n++;
            if (err) err_n++;
            if (ovf) ovf_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] kv);
        Y_n = ~kv;
        repeat (10) @(negedge clk);
        Y_n = 4'hF;
        repeat (10) @(negedge clk);
    endtask

    task automatic measure_first_evt();
        first_evt = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (key_evt && first_evt == 0) first_evt = i;
        end
    endtask

    initial begin
        rst_n = 1'b0; Y_n = 4'hF; clr = 1'b0; out_ready = 1'b0;
        #22;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bcd", out_bcd, 0);
        check("rst_digit_cnt", digit_cnt, 0);
        check("rst_pulses", {key_evt, err, ovf}, 0);
        check("rst_key_code", key_code, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("idle_no_evt", ev_n, 0);
        check("idle_no_err_ovf", err_n + ovf_n, 0);

        // single press of 5, latency from first sampling edge
        Y_n = 4'b1010;
        measure_first_evt();
        check("lat_first_evt_edge", first_evt, 6);
        Y_n = 4'hF;
        repeat (10) @(negedge clk);
        check("press5_evt_count", ev_n, 1);
        check("press5_key_code", key_code, 5);
        check("press5_digit_cnt", digit_cnt, 1);
        check("press5_bcd", out_bcd, 16'h0005);

        // bounce then settle
        for (int i = 0; i < 8; i++) begin
            Y_n = (i % 2 == 0) ? 4'b1010 : 4'b1111;
            @(negedge clk);
        end
        check("bounce_no_evt", ev_n, 1);
        press(4'd5);
        check("settle_evt_count", ev_n, 2);
        check("settle_bcd", out_bcd, 16'h0055);
        clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        check("clr_digit_cnt", digit_cnt, 0);
        check("clr_bcd", out_bcd, 0);

        // fill buffer, overflow, handshake
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check("full_valid", out_valid, 1);
        check("full_bcd", out_bcd, 16'h1234);
        check("full_cnt", digit_cnt, 4);
        check("full_evt_count", ev_n, 6);
        press(4'd7);
        check("ovf_count", ovf_n, 1);
        check("ovf_bcd_hold", out_bcd, 16'h1234);
        check("ovf_no_evt", ev_n, 6);
        out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;
        check("hs_valid", out_valid, 0);
        check("hs_cnt", digit_cnt, 0);
        check("hs_bcd", out_bcd, 0);

        // invalid code, then clr colliding with an accept
        press(4'd9);
        press(4'd15);
        check("err_count", err_n, 1);
        check("err_cnt_hold", digit_cnt, 1);
        check("err_bcd_hold", out_bcd, 16'h0009);
        ev_base = ev_n;
        Y_n = ~4'd8;
        repeat (5) @(negedge clk);
        clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        check("clr_acc_cnt", digit_cnt, 0);
        check("clr_acc_bcd", out_bcd, 0);
        Y_n = 4'hF;
        repeat (10) @(negedge clk);
        check("clr_acc_no_evt", ev_n, ev_base);

        // reset during debounce with key still held
        press(4'd6);
        check("pre_rst_cnt", digit_cnt, 1);
        Y_n = ~4'd2;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cnt", digit_cnt, 0);
        check("mid_rst_bcd", out_bcd, 0);
        check("mid_rst_code", key_code, 0);
        @(negedge clk) rst_n = 1'b1;
        measure_first_evt();
        check("rst_relat_edge", first_evt, 6);
        check("rst_re_code", key_code, 2);
        check("rst_re_cnt", digit_cnt, 1);
        Y_n = 4'hF;
        repeat (10) @(negedge clk);

        // long hold of key 3
        clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        ev_base = ev_n;
        Y_n = ~4'd3;
        repeat (206) @(negedge clk);
        Y_n = 4'hF;
        repeat (10) @(negedge clk);
`ifdef KEY_AUTOREPEAT_EN
        check("hold_evt_count", ev_n - ev_base, 4);
        check("hold_digit_cnt", digit_cnt, 4);
`else
        check("hold_evt_count", ev_n - ev_base, 1);
        check("hold_digit_cnt", digit_cnt, 1);
`endif
        check("hold_key_code", key_code, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/key_digit_collector.md
Name: key_digit_collector

Overview:
Downstream consumer of the 9-input active-low priority encoder (74HC147-style). Synchronises and debounces the encoder's active-low BCD code, emits one event per key press, and shifts accepted digits into a multi-digit BCD entry buffer. Once DIGITS digits are collected, the buffer is presented on a valid/ready output.

Parameters:
DEB_CYCLES, 4, consecutive stable synchroniser samples required to accept a press or a release; legal range 2..255
DIGITS, 4, number of BCD digits in the entry buffer; legal range 1..8
REPEAT_CYCLES, 64, auto-repeat period in cycles; used only with KEY_AUTOREPEAT_EN

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
Y_n  input  4  active-low encoder code; key value k = ~Y_n; 4'b1111 (k=0) = no key
clr  input  1  synchronous clear of buffer and count
out_ready  input  1  downstream accepts buffer
out_valid  output  1  buffer full and held
out_bcd  output  4*DIGITS  packed BCD; digit 0 (newest) in [3:0]
digit_cnt  output  4  digits currently held, 0..DIGITS
key_evt  output  1  one-cycle pulse per accepted digit 1..9
key_code  output  4  value of the last accepted digit; updated with key_evt
err  output  1  one-cycle pulse when the debounced k is 10..15
ovf  output  1  one-cycle pulse when a valid digit is dropped because out_valid=1

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_bcd=0, digit_cnt=0, key_evt=0, key_code=0, err=0, ovf=0. Synchroniser FFs=4'b1111; FSM=IDLE; counters=0.
- Y_n passes through a 2-FF synchroniser; k = ~(sync output).
- FSM states: IDLE, DEB, HELD.
- IDLE: if k!=0, go to DEB with cand=k, cnt=1.
- DEB:
  - k==cand and cnt==DEB_CYCLES-1: accept, go to HELD, cnt=0.
  - k==cand otherwise: cnt++.
  - k==0: go to IDLE.
  - k is another nonzero value: cand=k, cnt=1.
- Accept (registered, visible the cycle after the accepting edge):
  - cand 1..9 and out_valid=0: out_bcd = {out_bcd[4*DIGITS-5:0], cand}; digit_cnt++; key_evt=1; key_code=cand. If the new digit_cnt==DIGITS, out_valid=1 in the same cycle.
  - cand 1..9 and out_valid=1: ovf=1; no buffer change; key_evt=0.
  - cand 10..15: err=1; no buffer change.
- HELD:
  - k==0: cnt++; at cnt==DEB_CYCLES-1 go to IDLE.
  - k!=0: cnt=0. Code changes while held are ignored until a full release.
- Latency: with Y_n stable from sampling edge 1, key_evt is high after edge DEB_CYCLES+2 (edge 6 at default).
- Output handshake:
  - out_valid && out_ready at an edge: next cycle out_valid=0, digit_cnt=0, out_bcd=0.
  - out_bcd is stable while out_valid=1.
- Simultaneous events:
  - Accept in the handshake cycle: treated as out_valid=1, so ovf=1 and the digit is dropped.
  - clr=1 beats both accept and handshake: buffer, count and out_valid cleared; an accept in that cycle is discarded with no key_evt/ovf/err.
  - clr does not affect FSM or synchroniser state.
- Async reset mid-debounce or mid-hold: returns to IDLE. A key still pressed after reset is treated as a new press.

Optional Feature:
KEY_AUTOREPEAT_EN.
- Defined: in HELD with k==cand continuously, a repeat counter re-accepts cand every REPEAT_CYCLES cycles under the same accept rules (key_evt/ovf/err). The counter restarts on entering HELD and whenever k!=cand.
- Undefined: a held key produces exactly one accept; no repeat counter is instantiated.

Test Plan:
1. Reset release with Y_n=4'b1111 -> all outputs 0; no pulses for 50 cycles.
2. Y_n=4'b1010 for 10 cycles, then 4'b1111 for 10 -> exactly one key_evt, after edge 6; key_code=5, digit_cnt=1, out_bcd=16'h0005.
3. Y_n toggling 1010/1111 each cycle for 8 cycles, then 1010 stable -> no key_evt while bouncing; exactly one key_evt (code 5) after the settle.
4. Enter 1,2,3,4 with out_ready=0 -> out_valid=1, out_bcd=16'h1234, digit_cnt=4. Press 7 -> ovf pulse, out_bcd unchanged. Raise out_ready -> next cycle out_valid=0, digit_cnt=0, out_bcd=0.
5. Y_n=4'b0000 (k=15) held 10 cycles -> one err pulse; digit_cnt unchanged. Assert clr in the accept cycle of a digit-8 press -> buffer cleared; no key_evt.
6. rst_n low at DEB cnt=2 while the key is held -> outputs reset. After release of reset, key_evt arrives DEB_CYCLES+2 edges later. With KEY_AUTOREPEAT_EN and REPEAT_CYCLES=64, holding key 3 for 200 cycles after accept -> 4 key_evt total.
